// File: rtl/ppu_vram_loader_if.sv
// Signal bundle between the VRAM loader and its surroundings: command, source
// stream, status and the CPU-side PPU register bus.
interface ppu_vram_loader_if;
  logic        start;
  logic [15:0] cmd_vaddr;
  logic [8:0]  cmd_len;
  logic [7:0]  cmd_ctrl;
  logic        cmd_ctrl_en;
  logic        cmd_wait_vbl;
  logic [7:0]  src_data;
  logic        src_valid;
  logic        src_ready;
  logic [15:0] bus_addr;
  logic [7:0]  bus_dout;
  logic        bus_wr;
  logic [7:0]  bus_din;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    input  start, cmd_vaddr, cmd_len, cmd_ctrl, cmd_ctrl_en, cmd_wait_vbl,
    input  src_data, src_valid, bus_din,
    output src_ready, bus_addr, bus_dout, bus_wr, busy, done, err
  );

  modport slave (
    output start, cmd_vaddr, cmd_len, cmd_ctrl, cmd_ctrl_en, cmd_wait_vbl,
    output src_data, src_valid, bus_din,
    input  src_ready, bus_addr, bus_dout, bus_wr, busy, done, err
  );
endinterface

// File: rtl/ppu_vram_loader.sv
// Issues the PPU register sequence ($2000, $2002 polls, $2006 pair, spaced
// $2007 writes) for one "load N bytes at VRAM address A" command.
//
// state      | meaning
// S_IDLE     | waiting for start, bus idle
// S_CTRL     | $2000 write on bus
// S_STAT     | $2002 read on bus
// S_STAT_GAP | bus idle, read data (VBL flag) sampled
// S_ADDR_HI  | $2006 write, address high byte
// S_ADDR_LO  | $2006 write, address low byte
// S_DATA     | bus idle, src_ready high, waiting for a stream byte
// S_WRITE    | $2007 write of the latched byte
// S_FIN      | done pulse
module ppu_vram_loader #(
  parameter logic [15:0] POLL_MAX = 16'hFFFF
) (
  input logic              cpu_clk,
  input logic              reset,
  ppu_vram_loader_if.master lif
);
  typedef enum logic [3:0] {
    S_IDLE, S_CTRL, S_STAT, S_STAT_GAP, S_ADDR_HI, S_ADDR_LO, S_DATA, S_WRITE, S_FIN
  } state_t;

  state_t      state;
  logic [15:0] vaddr_q;
  logic [8:0]  remaining_q;
  logic        wait_q;
  logic [15:0] poll_cnt;
  logic [15:0] bus_addr_q;
  logic [7:0]  bus_dout_q;
  logic        bus_wr_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;
  logic        vbl_seen;

  assign vbl_seen      = (lif.bus_din & 8'h80) != 8'h00;
  assign lif.src_ready = (state == S_DATA);
  assign lif.bus_addr  = bus_addr_q;
  assign lif.bus_dout  = bus_dout_q;
  assign lif.bus_wr    = bus_wr_q;
  assign lif.busy      = busy_q;
  assign lif.done      = done_q;
  assign lif.err       = err_q;

  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      state       <= S_IDLE;
      vaddr_q     <= 16'h0000;
      remaining_q <= 9'd0;
      wait_q      <= 1'b0;
      poll_cnt    <= 16'h0000;
      bus_addr_q  <= 16'h0000;
      bus_dout_q  <= 8'h00;
      bus_wr_q    <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      // Bus outputs describe the state being entered; idle unless overridden.
      bus_addr_q <= 16'h0000;
      bus_dout_q <= 8'h00;
      bus_wr_q   <= 1'b1;
      done_q     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (lif.start) begin
            vaddr_q     <= lif.cmd_vaddr;
            remaining_q <= lif.cmd_len;
            wait_q      <= lif.cmd_wait_vbl;
            busy_q      <= 1'b1;
            err_q       <= 1'b0;
            if (lif.cmd_ctrl_en) begin
              state      <= S_CTRL;
              poll_cnt   <= 16'h0000;
              bus_addr_q <= 16'h2000;
              bus_dout_q <= lif.cmd_ctrl;
              bus_wr_q   <= 1'b0;
            end else begin
              state      <= S_STAT;
              poll_cnt   <= 16'h0001;
              bus_addr_q <= 16'h2002;
            end
          end
        end
        S_CTRL: begin
          state      <= S_STAT;
          poll_cnt   <= 16'h0001;
          bus_addr_q <= 16'h2002;
        end
        S_STAT: state <= S_STAT_GAP;
        S_STAT_GAP: begin
          if (wait_q && !vbl_seen) begin
            if (poll_cnt < POLL_MAX) begin
              state      <= S_STAT;
              poll_cnt   <= poll_cnt + 16'h0001;
              bus_addr_q <= 16'h2002;
            end else begin
              state  <= S_FIN;
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end
          end else begin
            state      <= S_ADDR_HI;
            bus_addr_q <= 16'h2006;
            bus_dout_q <= vaddr_q[15:8];
            bus_wr_q   <= 1'b0;
          end
        end
        S_ADDR_HI: begin
          state      <= S_ADDR_LO;
          bus_addr_q <= 16'h2006;
          bus_dout_q <= vaddr_q[7:0];
          bus_wr_q   <= 1'b0;
        end
        S_ADDR_LO: begin
          if (remaining_q == 9'd0) begin
            state  <= S_FIN;
            done_q <= 1'b1;
          end else begin
            state <= S_DATA;
          end
        end
        S_DATA: begin
          if (lif.src_valid) begin
            state       <= S_WRITE;
            remaining_q <= remaining_q - 9'd1;
            bus_addr_q  <= 16'h2007;
            bus_dout_q  <= lif.src_data;
            bus_wr_q    <= 1'b0;
          end
        end
        // The idle DATA cycle after each write gives the PPU time to apply
        // its late address increment.
        S_WRITE: begin
          if (remaining_q != 9'd0) begin
            state <= S_DATA;
          end else begin
            state  <= S_FIN;
            done_q <= 1'b1;
          end
        end
        S_FIN: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ppu_vram_loader.sv
// Directed bench for ppu_vram_loader: a transaction-level model builds the
// expected per-cycle bus picture of each command; a small PPU model answers reads.
module tb_ppu_vram_loader;
  localparam int POLL_MAX_TB = 4;

  typedef struct {
    logic [15:0] addr;
    logic        wr;
    logic [7:0]  dout;
    logic        rdy;
    logic        busy;
    logic        done;
    logic        err;
  } exp_t;

  logic cpu_clk = 1'b0;
  logic reset   = 1'b1;
  always #5 cpu_clk = ~cpu_clk;

  ppu_vram_loader_if lif();
  ppu_vram_loader #(.POLL_MAX(16'(POLL_MAX_TB))) dut (
    .cpu_clk(cpu_clk), .reset(reset), .lif(lif)
  );

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  exp_t cur_e;
  int   cyc = 0;
  int   done_k = -1;

  logic [7:0] src_bytes [0:255];
  int src_idx = 0, cur_len = 0, stall_left = 0;

  // PPU register model
  logic [7:0]  vram [0:16383];
  logic [15:0] ppu_addr = 16'h0000;
  logic        ppu_w = 1'b0;
  logic [7:0]  ppu_ctrl = 8'h00;
  int n2000 = 0, n2002 = 0, n2006 = 0, n2007 = 0;
  int rd_base = 0, vbl_zero = 0;
  int b2000, b2002, b2006, b2007;

  always @(posedge cpu_clk) begin
    lif.bus_din <= 8'h00;
    if (lif.bus_wr === 1'b1 && lif.bus_addr == 16'h2002) begin
      lif.bus_din <= ((n2002 - rd_base) >= vbl_zero) ? 8'h80 : 8'h00;
      n2002 <= n2002 + 1;
      ppu_w <= 1'b0;
    end
    if (lif.bus_wr === 1'b0) begin
      case (lif.bus_addr)
        16'h2000: begin ppu_ctrl <= lif.bus_dout; n2000 <= n2000 + 1; end
        16'h2006: begin
          if (!ppu_w) ppu_addr[15:8] <= lif.bus_dout;
          else        ppu_addr[7:0]  <= lif.bus_dout;
          ppu_w <= ~ppu_w;
          n2006 <= n2006 + 1;
        end
        16'h2007: begin
          vram[ppu_addr[13:0]] <= lif.bus_dout;
          ppu_addr <= ppu_addr + (ppu_ctrl[2] ? 16'd32 : 16'd1);
          n2007 <= n2007 + 1;
        end
        default: ;
      endcase
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic push(input logic [15:0] a, input logic w, input logic [7:0] d,
                      input logic r, input logic b, input logic dn, input logic e);
    exp_t x;
    x.addr = a; x.wr = w; x.dout = d; x.rdy = r; x.busy = b; x.done = dn; x.err = e;
    exp_q.push_back(x);
  endtask

  // Expected bus picture, one entry per cycle starting the cycle after start.
  task automatic build_exp(input logic [15:0] va, input int len, input logic [7:0] ctrl,
                           input logic cen, input logic wt, input int nzero,
                           input int stall, input int rst_k);
    int reads;
    bit tmo;
    if (cen) push(16'h2000, 1'b0, ctrl, 1'b0, 1'b1, 1'b0, 1'b0);
    tmo   = wt && (nzero >= POLL_MAX_TB);
    reads = !wt ? 1 : (tmo ? POLL_MAX_TB : nzero + 1);
    for (int i = 0; i < reads; i++) begin
      push(16'h2002, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
      push(16'h0000, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    if (tmo) begin
      push(16'h0000, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
      push(16'h0000, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    end else begin
      push(16'h2006, 1'b0, va[15:8], 1'b0, 1'b1, 1'b0, 1'b0);
      push(16'h2006, 1'b0, va[7:0],  1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < len; i++) begin
        for (int s = 0; s < 1 + ((i == 0) ? stall : 0); s++)
          push(16'h0000, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        push(16'h2007, 1'b0, src_bytes[i], 1'b0, 1'b1, 1'b0, 1'b0);
      end
      push(16'h0000, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
      push(16'h0000, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    if (rst_k > 0) begin
      while (exp_q.size() > rst_k) exp_q.pop_back();
      push(16'h0000, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      push(16'h0000, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  always @(posedge cpu_clk) begin
    #2;
    if (exp_q.size() > 0) begin
      cur_e = exp_q.pop_front();
      cyc++;
      chk($sformatf("c%0d bus_addr", cyc), 32'(lif.bus_addr), 32'(cur_e.addr));
      chk($sformatf("c%0d bus_wr", cyc), 32'(lif.bus_wr), 32'(cur_e.wr));
      chk($sformatf("c%0d bus_dout", cyc), 32'(lif.bus_dout), 32'(cur_e.dout));
      chk($sformatf("c%0d src_ready", cyc), 32'(lif.src_ready), 32'(cur_e.rdy));
      chk($sformatf("c%0d busy", cyc), 32'(lif.busy), 32'(cur_e.busy));
      chk($sformatf("c%0d done", cyc), 32'(lif.done), 32'(cur_e.done));
      chk($sformatf("c%0d err", cyc), 32'(lif.err), 32'(cur_e.err));
      if (lif.done === 1'b1) done_k = cyc;
    end
  end

  task automatic drive_src();
    if (lif.src_ready && stall_left > 0) begin
      lif.src_valid = 1'b0;
      stall_left--;
    end else begin
      lif.src_valid = (src_idx < cur_len);
      lif.src_data  = (src_idx < 256) ? src_bytes[src_idx] : 8'h00;
    end
    if (lif.src_valid && lif.src_ready) src_idx++;
  endtask

  task automatic run_cmd(input logic [15:0] va, input int len, input logic [7:0] ctrl,
                         input logic cen, input logic wt, input int nzero,
                         input int stall, input int bs_k, input int rst_k);
    int total;
    @(negedge cpu_clk);
    b2000 = n2000; b2002 = n2002; b2006 = n2006; b2007 = n2007;
    exp_q.delete();
    build_exp(va, len, ctrl, cen, wt, nzero, stall, rst_k);
    total = exp_q.size();
    cyc = 0; done_k = -1;
    rd_base = n2002; vbl_zero = nzero;
    cur_len = len; src_idx = 0; stall_left = stall;
    lif.start = 1'b1; lif.cmd_vaddr = va; lif.cmd_len = len[8:0];
    lif.cmd_ctrl = ctrl; lif.cmd_ctrl_en = cen; lif.cmd_wait_vbl = wt;
    drive_src();
    for (int k = 1; k <= total; k++) begin
      @(negedge cpu_clk);
      lif.start = (k == bs_k);
      if (k == bs_k) begin
        lif.cmd_vaddr = 16'h1234; lif.cmd_len = 9'd7;
        lif.cmd_ctrl = 8'hFF; lif.cmd_ctrl_en = 1'b1; lif.cmd_wait_vbl = 1'b1;
      end
      reset = (k == rst_k);
      drive_src();
    end
    lif.start = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    lif.start = 1'b0; lif.cmd_vaddr = 16'h0000; lif.cmd_len = 9'd0;
    lif.cmd_ctrl = 8'h00; lif.cmd_ctrl_en = 1'b0; lif.cmd_wait_vbl = 1'b0;
    lif.src_data = 8'h00; lif.src_valid = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge cpu_clk);
    chk("rst bus_addr", 32'(lif.bus_addr), 32'h0000);
    chk("rst bus_wr", 32'(lif.bus_wr), 32'd1);
    chk("rst bus_dout", 32'(lif.bus_dout), 32'h00);
    chk("rst src_ready", 32'(lif.src_ready), 32'd0);
    chk("rst busy", 32'(lif.busy), 32'd0);
    chk("rst done", 32'(lif.done), 32'd0);
    chk("rst err", 32'(lif.err), 32'd0);
    reset = 1'b0;
    @(negedge cpu_clk);
    chk("idle busy", 32'(lif.busy), 32'd0);

    // basic load
    src_bytes[0] = 8'hAA; src_bytes[1] = 8'hBB; src_bytes[2] = 8'hCC; src_bytes[3] = 8'hDD;
    run_cmd(16'h2000, 4, 8'h00, 1'b0, 1'b0, 0, 0, 0, 0);
    chk("basic done cycle", 32'(done_k), 32'd13);
    chk("basic n2002", 32'(n2002 - b2002), 32'd1);
    chk("basic n2006", 32'(n2006 - b2006), 32'd2);
    chk("basic n2007", 32'(n2007 - b2007), 32'd4);
    chk("basic vram0", 32'(vram[14'h2000]), 32'hAA);
    chk("basic vram1", 32'(vram[14'h2001]), 32'hBB);
    chk("basic vram2", 32'(vram[14'h2002]), 32'hCC);
    chk("basic vram3", 32'(vram[14'h2003]), 32'hDD);

    // start while busy must not disturb the in-flight command
    src_bytes[0] = 8'h01; src_bytes[1] = 8'h02; src_bytes[2] = 8'h03;
    run_cmd(16'h2100, 3, 8'h00, 1'b0, 1'b0, 0, 0, 3, 0);
    chk("busystart done cycle", 32'(done_k), 32'd11);
    chk("busystart n2000", 32'(n2000 - b2000), 32'd0);
    chk("busystart vram2", 32'(vram[14'h2102]), 32'h03);

    // stream stall
    src_bytes[0] = 8'h11; src_bytes[1] = 8'h22;
    run_cmd(16'h2400, 2, 8'h00, 1'b0, 1'b0, 0, 5, 0, 0);
    chk("stall done cycle", 32'(done_k), 32'd14);
    chk("stall n2007", 32'(n2007 - b2007), 32'd2);
    chk("stall vram0", 32'(vram[14'h2400]), 32'h11);
    chk("stall vram1", 32'(vram[14'h2401]), 32'h22);

    // VBL wait: three zero reads, then bit 7 set
    src_bytes[0] = 8'h77;
    run_cmd(16'h2800, 1, 8'h00, 1'b0, 1'b1, 3, 0, 0, 0);
    chk("vbl n2002", 32'(n2002 - b2002), 32'd4);
    chk("vbl n2006", 32'(n2006 - b2006), 32'd2);
    chk("vbl vram", 32'(vram[14'h2800]), 32'h77);

    // VBL timeout
    run_cmd(16'h2C00, 3, 8'h00, 1'b0, 1'b1, 1000, 0, 0, 0);
    chk("tmo n2002", 32'(n2002 - b2002), 32'd4);
    chk("tmo n2006", 32'(n2006 - b2006), 32'd0);
    chk("tmo n2007", 32'(n2007 - b2007), 32'd0);
    chk("tmo done cycle", 32'(done_k), 32'd9);
    chk("tmo err held", 32'(lif.err), 32'd1);

    // len = 0
    run_cmd(16'h23C0, 0, 8'h00, 1'b0, 1'b0, 0, 0, 0, 0);
    chk("len0 n2006", 32'(n2006 - b2006), 32'd2);
    chk("len0 n2007", 32'(n2007 - b2007), 32'd0);
    chk("len0 done cycle", 32'(done_k), 32'd5);

    // ctrl write, +32 increment, 256 bytes
    for (int i = 0; i < 256; i++) src_bytes[i] = 8'(i) ^ 8'h5A;
    run_cmd(16'h3F00, 256, 8'h04, 1'b1, 1'b0, 0, 0, 0, 0);
    chk("ctrl n2000", 32'(n2000 - b2000), 32'd1);
    chk("ctrl n2007", 32'(n2007 - b2007), 32'd256);
    chk("ctrl done cycle", 32'(done_k), 32'd518);
    chk("ctrl vram first", 32'(vram[14'h3F00]), 32'h5A);
    chk("ctrl vram last", 32'(vram[14'h1EE0]), 32'hA5);

    // reset asserted during the first WRITE cycle
    src_bytes[0] = 8'h91; src_bytes[1] = 8'h92; src_bytes[2] = 8'h93; src_bytes[3] = 8'h94;
    run_cmd(16'h2000, 4, 8'h00, 1'b0, 1'b0, 0, 0, 0, 6);
    chk("rstmid n2007", 32'(n2007 - b2007), 32'd1);
    @(negedge cpu_clk);
    chk("rstmid busy after", 32'(lif.busy), 32'd0);
    chk("rstmid bus_addr after", 32'(lif.bus_addr), 32'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
